// File: rtl/keccak_round_ctrl.sv
// Iterative Keccak-f[1600] control: absorbs one rate block, steps an external
// round datapath 24 times and hands the final state out with valid/ready.
module keccak_round_ctrl #(
  parameter int RATE = 1088
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [RATE-1:0]   blk_data,
  output logic [1599:0]     perm_state,
  output logic [7:0]        perm_rc,
  input  logic [1599:0]     perm_next,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              busy
);

  localparam int RATE_LANES = RATE / 64;
  localparam logic [4:0] LAST_ROUND = 5'd23;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t           fsm_reg;
  logic [1599:0]  state_reg;
  logic [4:0]     rnd_reg;
  logic           blk_ready_reg;
  logic           st_valid_reg;
  logic           busy_reg;
  logic [7:0]     rc_reg;
  logic [1599:0]  absorb_word;

  // Message block lands in the top RATE bits, lane 0 first; capacity lanes get zero.
  generate
    for (genvar gi = 0; gi < 25; gi++) begin : g_lane
      if (gi < RATE_LANES) begin : g_rate
        assign absorb_word[1599-64*gi -: 64] = blk_data[RATE-1-64*gi -: 64];
      end else begin : g_cap
        assign absorb_word[1599-64*gi -: 64] = 64'h0;
      end
    end
  endgenerate

  // Compact round constants: RC bits {63,31,15,7,3,(2=0),1,0} packed into a byte.
  function automatic logic [7:0] rc_lookup(input logic [4:0] r);
    logic [7:0] rc;
    case (r)
      5'd0:  rc = 8'h01;  5'd1:  rc = 8'h32;  5'd2:  rc = 8'hBA;  5'd3:  rc = 8'hE0;
      5'd4:  rc = 8'h3B;  5'd5:  rc = 8'h41;  5'd6:  rc = 8'hF1;  5'd7:  rc = 8'hA9;
      5'd8:  rc = 8'h1A;  5'd9:  rc = 8'h18;  5'd10: rc = 8'h69;  5'd11: rc = 8'h4A;
      5'd12: rc = 8'h7B;  5'd13: rc = 8'h9B;  5'd14: rc = 8'hB9;  5'd15: rc = 8'hA3;
      5'd16: rc = 8'hA2;  5'd17: rc = 8'h90;  5'd18: rc = 8'h2A;  5'd19: rc = 8'hCA;
      5'd20: rc = 8'hF1;  5'd21: rc = 8'hB0;  5'd22: rc = 8'h41;  5'd23: rc = 8'hE8;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      rnd_reg       <= 5'd0;
      blk_ready_reg <= 1'b1;
      st_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      rc_reg        <= 8'h00;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (blk_valid) begin
            state_reg     <= (init ? '0 : state_reg) ^ absorb_word;
            rnd_reg       <= 5'd0;
            fsm_reg       <= ROUND;
            blk_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            rc_reg        <= rc_lookup(5'd0);
          end else if (init) begin
            state_reg <= '0;
          end
        end
        ROUND: begin
          state_reg <= perm_next;
          if (rnd_reg == LAST_ROUND) begin
            rnd_reg      <= 5'd0;
            fsm_reg      <= DONE;
            busy_reg     <= 1'b0;
            st_valid_reg <= 1'b1;
            rc_reg       <= 8'h00;
          end else begin
            // perm_rc is registered, so it is loaded one round ahead.
            rnd_reg <= rnd_reg + 5'd1;
            rc_reg  <= rc_lookup(rnd_reg + 5'd1);
          end
        end
        DONE: begin
          if (init || st_ready) begin
            if (init) begin
              state_reg <= '0;
            end
            fsm_reg       <= IDLE;
            st_valid_reg  <= 1'b0;
            blk_ready_reg <= 1'b1;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign perm_state = state_reg;
  assign perm_rc    = rc_reg;
  assign blk_ready  = blk_ready_reg;
  assign st_valid   = st_valid_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: a reference round function closes the datapath
// loop; expected round constants and results are queued and checked by a monitor.
module tb_keccak_round_ctrl;

  localparam logic [7:0] RC_EXP [24] = '{
    8'h01, 8'h32, 8'hBA, 8'hE0, 8'h3B, 8'h41, 8'hF1, 8'hA9,
    8'h1A, 8'h18, 8'h69, 8'h4A, 8'h7B, 8'h9B, 8'hB9, 8'hA3,
    8'hA2, 8'h90, 8'h2A, 8'hCA, 8'hF1, 8'hB0, 8'h41, 8'hE8};
  localparam int ROT [25] = '{
    0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
    41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  localparam logic [1599:0] PATTERN = {25{64'h0123_4567_89AB_CDEF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          init = 1'b0, blk_valid = 1'b0, st_ready = 1'b0;
  logic [1087:0] blk_data = '0;
  logic          blk_ready, st_valid, busy;
  logic [1599:0] perm_state, perm_next;
  logic [7:0]    perm_rc;

  logic          init2 = 1'b0, blk_valid2 = 1'b0, st_ready2 = 1'b0;
  logic [575:0]  blk_data2 = '0;
  logic          blk_ready2, st_valid2, busy2;
  logic [1599:0] perm_state2;
  logic [7:0]    perm_rc2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0]    rc_q[$];
  logic [1599:0] res_q[$];
  logic [1599:0] model_state = '0;

  keccak_round_ctrl #(.RATE(1088)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .perm_state(perm_state), .perm_rc(perm_rc), .perm_next(perm_next),
    .st_valid(st_valid), .st_ready(st_ready), .busy(busy));

  keccak_round_ctrl #(.RATE(576)) dut2 (
    .clk(clk), .rst_n(rst_n), .init(init2), .blk_valid(blk_valid2), .blk_ready(blk_ready2),
    .blk_data(blk_data2), .perm_state(perm_state2), .perm_rc(perm_rc2), .perm_next(PATTERN),
    .st_valid(st_valid2), .st_ready(st_ready2), .busy(busy2));

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
  endfunction

  function automatic logic [63:0] lane_of(input logic [1599:0] s, input int i);
    logic [63:0] l;
    for (int z = 0; z < 64; z++) l[z] = s[1599-64*i-z];
    return l;
  endfunction

  function automatic logic [1599:0] round_fn(input logic [1599:0] s, input logic [7:0] rc);
    logic [63:0] a [25];
    logic [63:0] b [25];
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] rcw;
    logic [1599:0] r;
    for (int i = 0; i < 25; i++) a[i] = lane_of(s, i);
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rol(c[(x+1)%5], 1);
    for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y + 5*((2*x + 3*y) % 5)] = rol(a[x+5*y], ROT[x+5*y]);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        a[x+5*y] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
    rcw = '0;
    rcw[0] = rc[0]; rcw[1] = rc[1]; rcw[3] = rc[3]; rcw[7] = rc[4];
    rcw[15] = rc[5]; rcw[31] = rc[6]; rcw[63] = rc[7];
    a[0] = a[0] ^ rcw;
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < 64; z++) r[1599-64*i-z] = a[i][z];
    return r;
  endfunction

  function automatic logic [1599:0] keccak_f(input logic [1599:0] s);
    logic [1599:0] t = s;
    for (int k = 0; k < 24; k++) t = round_fn(t, RC_EXP[k]);
    return t;
  endfunction

  assign perm_next = round_fn(perm_state, perm_rc);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < 25; i++) begin
        if (act[1599-64*i -: 64] !== exp[1599-64*i -: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, i,
                   act[1599-64*i -: 64], exp[1599-64*i -: 64]);
          break;
        end
      end
    end
  endtask

  // Monitor: one rc per ROUND cycle, one full state per st_valid rise.
  initial begin
    logic prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (busy) begin
          if (rc_q.size() == 0) chk("rc_unexpected", {56'h0, perm_rc}, 64'h0);
          else chk("perm_rc", {56'h0, perm_rc}, {56'h0, rc_q.pop_front()});
        end
        if (st_valid && !prev_v) begin
          if (res_q.size() == 0) chk("result_unexpected", 64'h1, 64'h0);
          else chk_state("result", perm_state, res_q.pop_front());
          $display("result t=%0t lane00=%h", $time, lane_of(perm_state, 0));
        end
        prev_v = st_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic absorb(input logic [1087:0] blk, input logic ini, output int acc);
    int w = 0;
    logic [1599:0] exp_s;
    blk_valid = 1'b1;
    blk_data  = blk;
    init      = ini;
    while (!blk_ready && w < 100) begin
      step();
      w++;
    end
    chk("accept_wait", {63'h0, blk_ready}, 64'h1);
    exp_s = (ini ? '0 : model_state) ^ {blk, 512'h0};
    for (int k = 0; k < 24; k++) rc_q.push_back(RC_EXP[k]);
    model_state = keccak_f(exp_s);
    res_q.push_back(model_state);
    step();
    acc = cyc;
    blk_valid = 1'b0;
    init      = 1'b0;
    chk_state("absorb_state", perm_state, exp_s);
    $display("absorb cyc=%0d init=%0d lane00=%h", acc, ini, lane_of(exp_s, 0));
  endtask

  task automatic wait_done(input string name);
    int lat = 0;
    while (!st_valid && lat < 100) begin
      step();
      lat++;
    end
    chk(name, lat, 24);
  endtask

  initial begin
    int acc1, acc2, w;
    logic [1599:0] snap;

    // Reset values
    repeat (2) step();
    chk("rst_blk_ready", {63'h0, blk_ready}, 64'h1);
    chk("rst_st_valid", {63'h0, st_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy | busy2}, 64'h0);
    chk("rst_perm_rc", {48'h0, perm_rc, perm_rc2}, 64'h0);
    chk_state("rst_state", perm_state, '0);
    rst_n = 1'b1;
    step();

    // RATE=576: all-ones block over zero, then over a known non-zero state
    blk_valid2 = 1'b1;
    blk_data2  = '1;
    step();
    blk_valid2 = 1'b0;
    chk("r576_busy", {63'h0, busy2}, 64'h1);
    chk_state("r576_absorb0", perm_state2, {{576{1'b1}}, 1024'h0});
    w = 0;
    while (!st_valid2 && w < 100) begin
      step();
      w++;
    end
    chk("r576_latency", w, 24);
    chk_state("r576_result", perm_state2, PATTERN);
    st_ready2 = 1'b1;
    step();
    st_ready2 = 1'b0;
    chk("r576_ready", {63'h0, blk_ready2}, 64'h1);
    blk_valid2 = 1'b1;
    step();
    blk_valid2 = 1'b0;
    chk_state("r576_absorb1", perm_state2, {~PATTERN[1599:1024], PATTERN[1023:0]});

    // Zero block through the reference datapath
    absorb('0, 1'b0, acc1);
    wait_done("latency_zero");
    chk("lane00_zero", lane_of(perm_state, 0), 64'hF125_8F79_40E1_DDE7);

    // Backpressure with a rejected blk_valid pulse
    snap = perm_state;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        blk_valid = 1'b1;
        blk_data  = {17{64'hDEAD_BEEF_0BAD_F00D}};
      end
      step();
      blk_valid = 1'b0;
      chk("bp_st_valid", {63'h0, st_valid}, 64'h1);
      chk("bp_blk_ready", {63'h0, blk_ready | busy}, 64'h0);
      chk_state("bp_state", perm_state, snap);
    end
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    chk("release_ready", {63'h0, blk_ready}, 64'h1);
    chk_state("release_retained", perm_state, snap);

    // init together with blk_valid over a non-zero state
    absorb({17{64'h1357_9BDF_2468_ACE0}}, 1'b1, acc1);
    wait_done("latency_init");

    // init in DONE clears state and returns to IDLE without st_ready
    init = 1'b1;
    step();
    init = 1'b0;
    model_state = '0;
    chk("done_init_ready", {63'h0, blk_ready}, 64'h1);
    chk("done_init_valid", {63'h0, st_valid}, 64'h0);
    chk_state("done_init_state", perm_state, '0);

    // Back-to-back blocks with st_ready held high
    st_ready = 1'b1;
    absorb({17{64'hA5A5_0000_FFFF_1234}}, 1'b0, acc1);
    wait_done("latency_b2b0");
    absorb({17{64'h0F0F_F0F0_5555_AAAA}}, 1'b0, acc2);
    chk("b2b_interval", acc2 - acc1, 26);
    wait_done("latency_b2b1");
    step();
    st_ready = 1'b0;

    // Asynchronous reset in round 10, then a fresh absorb
    absorb({17{64'h7777_1111_3333_9999}}, 1'b0, acc1);
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    rc_q.delete();
    res_q.delete();
    model_state = '0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_blk_ready", {63'h0, blk_ready}, 64'h1);
    chk("arst_st_valid", {63'h0, st_valid}, 64'h0);
    chk("arst_perm_rc", {56'h0, perm_rc}, 64'h0);
    chk_state("arst_state", perm_state, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    absorb({17{64'hCAFE_BABE_0000_0001}}, 1'b0, acc1);
    wait_done("latency_after_rst");
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;

    repeat (3) step();
    chk("rc_q_empty", rc_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
